// File: rtl/ram_pkg.sv
// Shared types and constants for the PSRAM arbiter: FSM states, strobe patterns
// ordered {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}, and the default wait time.
package ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRecover
  } ram_state_e;

  localparam logic [6:0] CTRL_IDLE  = 7'b111_1111;
  localparam logic [6:0] CTRL_READ  = 7'b000_0100;
  localparam logic [6:0] CTRL_WRITE = 7'b000_1000;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 6;

endpackage

// File: rtl/ram_grant.sv
// Two-way round-robin picker. The pointer names the port favoured on a tie and
// only moves when the arbiter commits a grant.
module ram_grant (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After serving port 0 favour port 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the asynchronous 16-bit PSRAM: grants one port,
// holds the strobes for WAIT_CYCLES clocks, then acks during a one-cycle bus-released recovery.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  output logic              p0_ack,
  output logic [15:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  output logic              p1_ack,
  output logic [15:0]       p1_rdata,
  inout  wire  [15:0]       MemDB,
  output logic [26:1]       MemAdr,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  ram_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata0_q, rdata0_d;
  logic [15:0]       rdata1_q, rdata1_d;

  logic [1:0] gnt;
  logic       advance;
  logic       last_cnt;
  logic [6:0] ctrl;
  logic       drive_en;

  ram_grant u_grant (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req, p0_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  assign advance  = (state_q == StIdle) && (|gnt);
  assign last_cnt = (cnt_q == CntW'(WAIT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (advance) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (last_cnt) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecover: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Transaction is frozen at grant; ports are never re-sampled afterwards.
  always_comb begin
    we_d     = we_q;
    port_d   = port_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (advance) begin
      port_d  = gnt[1];
      we_d    = gnt[1] ? p1_we : p0_we;
      addr_d  = gnt[1] ? p1_addr : p0_addr;
      wdata_d = gnt[1] ? p1_wdata : p0_wdata;
    end
    if ((state_q == StAccess) && last_cnt && !we_q) begin
      if (port_q) begin
        rdata1_d = MemDB;
      end else begin
        rdata0_d = MemDB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      we_q     <= we_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode from state only, so an asynchronous reset releases the pins at once.
  always_comb begin
    ctrl     = CTRL_IDLE;
    drive_en = 1'b0;
    p0_ack   = 1'b0;
    p1_ack   = 1'b0;
    unique case (state_q)
      StAccess: begin
        ctrl     = we_q ? CTRL_WRITE : CTRL_READ;
        drive_en = we_q;
      end
      StRecover: begin
        p0_ack = !port_q;
        p1_ack = port_q;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

  always_comb begin
    MemAdr             = '0;
    MemAdr[ADDR_W:1]   = addr_q;
  end

  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl;
  assign MemDB    = drive_en ? wdata_q : 16'hzzzz;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a default build plus a WAIT_CYCLES=2 build,
// each attached to a small PSRAM model on a pulled-up data bus.
module tb_ram_arbiter;

  localparam logic [6:0] C_IDLE  = 7'b111_1111;
  localparam logic [6:0] C_READ  = 7'b000_0100;
  localparam logic [6:0] C_WRITE = 7'b000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [22:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  wire  [15:0] MemDB;
  logic [26:1] MemAdr;
  logic        RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
  logic [6:0]  ctrl;

  logic        b_req;
  logic [22:0] b_addr;
  logic        b_zero;
  logic [22:0] b_zaddr;
  logic [15:0] b_zdata;
  logic        b_p0_ack, b_p1_ack;
  logic [15:0] b_p0_rdata, b_p1_rdata;
  wire  [15:0] b_MemDB;
  logic [26:1] b_MemAdr;
  logic        b_adv, b_clk, b_cs, b_oe, b_wr, b_lb, b_ub;
  logic [6:0]  b_ctrl;

  logic [15:0] model [0:15];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .MemDB(MemDB), .MemAdr(MemAdr),
    .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE),
    .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB)
  );

  ram_arbiter #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .p0_req(b_req), .p0_we(b_zero), .p0_addr(b_addr), .p0_wdata(b_zdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_zero), .p1_we(b_zero), .p1_addr(b_zaddr), .p1_wdata(b_zdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .MemDB(b_MemDB), .MemAdr(b_MemAdr),
    .RamAdv(b_adv), .RamClk(b_clk), .RamCS(b_cs), .MemOE(b_oe),
    .MemWR(b_wr), .RamLB(b_lb), .RamUB(b_ub)
  );

  assign ctrl   = {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};
  assign b_ctrl = {b_adv, b_clk, b_cs, b_oe, b_wr, b_lb, b_ub};

  // Released bus reads as 16'hFFFF through the pull-ups.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (MemDB[i]);
    pullup (b_MemDB[i]);
  end

  // PSRAM models: word-indexed by the low address bits.
  assign MemDB   = (!RamCS && !MemOE) ? model[MemAdr[4:1]] : 16'hzzzz;
  assign b_MemDB = (!b_cs && !b_oe) ? 16'hA5A5 : 16'hzzzz;

  always @(posedge clk) begin
    if (!RamCS && !MemWR) model[MemAdr[4:1]] <= MemDB;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    model[0] = 16'hBEEF;
    rst = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    b_req = 0; b_addr = '0; b_zero = 0; b_zaddr = '0; b_zdata = '0;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_adr", 32'(MemAdr), 32'h0);
    check("rst_db", 32'(MemDB), 32'hFFFF);
    check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'h0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 32'h0);
    step(); step();
    rst = 1'b1;
    step();

    // Port 0 read of 0x10
    p0_req = 1; p0_we = 0; p0_addr = 23'h000010;
    for (int c = 1; c <= 6; c++) begin
      step();
      check("rd_ctrl", 32'(ctrl), 32'(C_READ));
      check("rd_ack0", 32'(p0_ack), 32'h0);
      check("rd_ack1", 32'(p1_ack), 32'h0);
    end
    check("rd_adr", 32'(MemAdr), 32'h10);
    step();
    check("rd_ack_c7", 32'(p0_ack), 32'h1);
    check("rd_p1_quiet", 32'(p1_ack), 32'h0);
    check("rd_data", 32'(p0_rdata), 32'hBEEF);
    check("rd_rec_ctrl", 32'(ctrl), 32'(C_IDLE));
    p0_req = 0;
    step();
    check("rd_idle_ack", 32'(p0_ack), 32'h0);

    // Port 1 write 0x1234 to 0x7FFFFF, then read it back
    p1_req = 1; p1_we = 1; p1_addr = 23'h7FFFFF; p1_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      step();
      check("wr_ctrl", 32'(ctrl), 32'(C_WRITE));
      check("wr_db", 32'(MemDB), 32'h1234);
    end
    check("wr_adr", 32'(MemAdr), 32'h07FFFFF);
    step();
    check("wr_ack", 32'(p1_ack), 32'h1);
    check("wr_rec_db", 32'(MemDB), 32'hFFFF);
    check("wr_rec_ctrl", 32'(ctrl), 32'(C_IDLE));
    p1_req = 0;
    step();
    p1_req = 1; p1_we = 0;
    for (int c = 1; c <= 7; c++) step();
    check("rb_ack", 32'(p1_ack), 32'h1);
    check("rb_data", 32'(p1_rdata), 32'h1234);
    check("rb_p0_held", 32'(p0_rdata), 32'hBEEF);
    p1_req = 0;
    step();

    // Both ports requesting continuously: 0,1,0,1 every 8 cycles
    p0_req = 1; p0_we = 0; p0_addr = 23'h000010;
    p1_req = 1; p1_we = 0; p1_addr = 23'h7FFFFF;
    for (int c = 1; c <= 31; c++) begin
      step();
      check("rr_ack0", 32'(p0_ack), 32'((c % 16) == 7));
      check("rr_ack1", 32'(p1_ack), 32'((c % 16) == 15));
    end
    p0_req = 0; p1_req = 0;
    step();
    check("rr_idle", 32'(ctrl), 32'(C_IDLE));
    check("rr_data", {p1_rdata, p0_rdata}, 32'h1234_BEEF);

    // Port 0 drops req at access cycle 3
    p0_req = 1; p0_we = 0; p0_addr = 23'h000010;
    step(); step(); step();
    p0_req = 0; p0_addr = 23'h000003;
    step();
    check("drop_adr", 32'(MemAdr), 32'h10);
    check("drop_ctrl", 32'(ctrl), 32'(C_READ));
    step(); step(); step();
    check("drop_ack", 32'(p0_ack), 32'h1);
    for (int c = 8; c <= 12; c++) begin
      step();
      check("drop_no_2nd", {25'd0, ctrl}, {25'd0, C_IDLE});
      check("drop_no_ack", 32'(p0_ack), 32'h0);
    end

    // Reset in the middle of a write
    p0_req = 1; p0_we = 1; p0_addr = 23'h000005; p0_wdata = 16'hCAFE;
    for (int c = 1; c <= 4; c++) step();
    check("mid_ctrl", 32'(ctrl), 32'(C_WRITE));
    check("mid_db", 32'(MemDB), 32'hCAFE);
    rst = 1'b0;
    #1;
    check("arst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("arst_db", 32'(MemDB), 32'hFFFF);
    for (int c = 0; c < 4; c++) begin
      step();
      check("arst_no_ack", {30'd0, p1_ack, p0_ack}, 32'h0);
    end
    p0_req = 0;
    check("arst_rdata", {p1_rdata, p0_rdata}, 32'h0);
    rst = 1'b1;
    step();
    p1_req = 1; p1_we = 0; p1_addr = 23'h000010;
    for (int c = 1; c <= 6; c++) step();
    check("post_ack_early", 32'(p1_ack), 32'h0);
    step();
    check("post_ack", 32'(p1_ack), 32'h1);
    check("post_data", 32'(p1_rdata), 32'hBEEF);
    p1_req = 0;
    step();

    // WAIT_CYCLES = 2 build: ack at cycle 3, held req regranted at cycle 4
    b_req = 1; b_addr = 23'h000003;
    step();
    check("w2_c1", 32'(b_ctrl), 32'(C_READ));
    step();
    check("w2_c2", 32'(b_ctrl), 32'(C_READ));
    check("w2_c2_ack", 32'(b_p0_ack), 32'h0);
    step();
    check("w2_ack", 32'(b_p0_ack), 32'h1);
    check("w2_data", 32'(b_p0_rdata), 32'hA5A5);
    check("w2_rec_ctrl", 32'(b_ctrl), 32'(C_IDLE));
    step();
    check("w2_c4_idle", 32'(b_ctrl), 32'(C_IDLE));
    step();
    b_req = 0;
    check("w2_c5_regrant", 32'(b_ctrl), 32'(C_READ));
    step(); step();
    check("w2_c7_ack", 32'(b_p0_ack), 32'h1);
    step();
    check("w2_done", 32'(b_ctrl), 32'(C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the board's asynchronous 16-bit PSRAM. It shares one external memory interface between the audio playback reader (port 0) and the sample loader (port 1). It owns the PSRAM strobes, address bus and tri-state data bus. It replaces ad-hoc direct drive of the control pins by a single requester.

## Interface
- `ADDR_W`, 23: word address width. Drives the low bits of `MemAdr`; the upper bits are tied 0.
- `WAIT_CYCLES`, 6: clocks the strobes are held per access, minimum 2.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `p0_req`, `p1_req` in 1: access request, held until the matching ack.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read. Stable while req is high.
- `p0_addr`, `p1_addr` in ADDR_W: word address. Stable while req is high.
- `p0_wdata`, `p1_wdata` in 16: write data. Stable while req is high.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out 16: read data. Valid from the ack cycle; held until that port's next read completes.
- `MemDB` inout 16: PSRAM data bus.
- `MemAdr` out 26 (`[26:1]`): PSRAM address, `{zeros, addr}`.
- `RamAdv`, `RamClk`, `RamCS`, `MemOE`, `MemWR`, `RamLB`, `RamUB` out 1: active-low PSRAM controls.

## Operation
- FSM states:
  - IDLE: all controls high, `MemDB` = Z, counter cleared.
  - ACCESS: strobes asserted.
  - RECOVER: controls high, bus released, ack high.
- IDLE, no request pending: stays in IDLE.
- IDLE, any request high: grant one port.
  - On the grant edge, latch `we`, `addr` and `wdata` into internal registers and set `MemAdr`.
  - Then go to ACCESS.
- Grant rule when both ports request:
  - Two-way round-robin; the port not granted last wins.
  - After reset the pointer favours port 0.
  - A single requester always wins.
- ACCESS, read: `RamAdv`, `RamClk`, `RamCS`, `MemOE`, `RamLB`, `RamUB` = 0; `MemWR` = 1; `MemDB` = Z.
- ACCESS, write: `RamAdv`, `RamClk`, `RamCS`, `MemWR`, `RamLB`, `RamUB` = 0; `MemOE` = 1; `MemDB` driven with the latched wdata.
- Counter: counts 0..WAIT_CYCLES-1 in ACCESS. On the edge leaving count WAIT_CYCLES-1:
  - for a read, `MemDB` is sampled into the granted port's rdata register;
  - the FSM goes to RECOVER.
- RECOVER: lasts 1 cycle, granted port's ack = 1, then IDLE.
- A transaction is committed at grant. Dropping req mid-access does not abort it; the ack still pulses.
- Address and data are never re-sampled from the ports after grant. Port inputs may change freely once ack is seen.
- Reset values: all controls 1; `MemAdr` 0; `MemDB` Z; acks 0; both rdata 0; FSM in IDLE; RR pointer favours port 0.
- Reset mid-access: controls go high and `MemDB` releases asynchronously; no ack is issued.

## Timing
- Let req be first sampled high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES;
  - RECOVER with ack occupies cycle WAIT_CYCLES+1;
  - IDLE returns at WAIT_CYCLES+2.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles (8 at default).
- A requester that sees ack and keeps req high is treated as a new request; it is sampled in the following IDLE cycle.
- Worst-case latency for a port under contention: 2·(WAIT_CYCLES+2) cycles.
- `MemDB` is driven only in write ACCESS cycles. RECOVER guarantees one released cycle between any write and the next access.
- Counter width is `$clog2(WAIT_CYCLES)` and must not wrap within ACCESS.

## Structure
- Package `ram_pkg` holds:
  - state enum (IDLE, ACCESS, RECOVER);
  - 7-bit control constants CTRL_IDLE = all 1, CTRL_READ, CTRL_WRITE, ordered {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};
  - the default WAIT_CYCLES.
- Sub-module `ram_grant`: two-way round-robin picker.
  - Inputs: req[1:0], advance.
  - Output: one-hot grant.
  - Pointer updates only on advance, which is asserted on the grant edge.
- All remaining logic (FSM, counter, latches, tri-state) lives in `ram_arbiter`.

## Test plan
- Port 0 read, addr 0x000010, PSRAM model returns 0xBEEF → controls = CTRL_READ for cycles 1..6, `p0_ack` at cycle 7, `p0_rdata` = 0xBEEF, `p1_ack` stays 0.
- Port 1 write, addr 0x7FFFFF, data 0x1234 → `MemAdr` = 0x07FFFFF, `MemWR` low for 6 cycles, `MemDB` = 0x1234 only in those cycles, Z in RECOVER, then read-back gives 0x1234.
- Both ports request continuously → grants alternate 0,1,0,1 starting with port 0; acks spaced 8 cycles apart.
- Port 0 drops req at ACCESS cycle 3 → access completes, `p0_ack` pulses at cycle 7, no second access.
- `rst` asserted at ACCESS cycle 4 of a write → all controls 1 and `MemDB` Z before the next edge; no ack; after release, a fresh request completes normally.
- `WAIT_CYCLES` = 2 build, single read → ack at cycle 3, next request granted at cycle 4.
